// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// FSM state encoding and the iteration-counter width helper.
package seq_restoring_divider_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold the full iteration count
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus of the restoring divider.
interface seq_restoring_divider_if
    import seq_restoring_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) ();

    logic                  start;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_restoring_divider_div_trial_sub.sv
// Combinational trial subtractor for one restoring-division step; isolated so
// a faster adder structure can replace it without touching the FSM.
module div_trial_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// single-cycle done pulse and a short-circuit path for a zero divisor.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_restoring_divider_if.slave dif
);

    localparam int CW = cnt_w(DIVIDEND_W);

    state_t                state;
    logic [DIVISOR_W:0]    prem;
    logic [DIVIDEND_W-1:0] shreg;
    logic [DIVISOR_W-1:0]  dvsr;
    logic [CW-1:0]         cnt;

    logic                  busy_r, done_r, dbz_r;
    logic [DIVIDEND_W-1:0] quot_r;
    logic [DIVISOR_W-1:0]  rem_r;

    logic [DIVISOR_W:0]    trial, diff, nrem;
    logic                  borrow;
    logic [DIVIDEND_W-1:0] nshreg;
    logic                  accept;
    logic                  prem_msb_unused;

    // prem stays below the divisor, so its top bit is always zero going in
    assign trial           = {prem[DIVISOR_W-1:0], shreg[DIVIDEND_W-1]};
    assign prem_msb_unused = prem[DIVISOR_W];

    div_trial_sub #(.W(DIVISOR_W + 1)) u_trial (
        .a      (trial),
        .b      ({1'b0, dvsr}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign nrem   = borrow ? trial : diff;
    assign nshreg = {shreg[DIVIDEND_W-2:0], ~borrow};
    assign accept = dif.start && (state != CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            prem   <= '0;
            shreg  <= '0;
            dvsr   <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        dvsr  <= dif.divisor;
                        prem  <= '0;
                        shreg <= dif.dividend;
                        cnt   <= '0;
                        if (dif.divisor == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            dbz_r  <= 1'b1;
                            quot_r <= '1;
                            rem_r  <= dif.dividend[DIVISOR_W-1:0];
                        end else begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    prem  <= nrem;
                    shreg <= nshreg;
                    cnt   <= cnt + 1'b1;
                    // Last step: publish straight from the next-state values
                    if (cnt == CW'(DIVIDEND_W - 1)) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        dbz_r  <= 1'b0;
                        quot_r <= nshreg;
                        rem_r  <= nrem[DIVISOR_W-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dif.busy        = busy_r;
    assign dif.done        = done_r;
    assign dif.quotient    = quot_r;
    assign dif.remainder   = rem_r;
    assign dif.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive checks of the restoring divider against an
// arithmetic reference that tracks when each result becomes visible.
module tb_seq_restoring_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_restoring_divider_if dif ();

    seq_restoring_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: results from / and %, visible 8 edges after acceptance
    // (or at the accepting edge itself for a zero divisor).
    int         cyc = 0, m_due = 0;
    logic       m_busy = 0, m_done = 0, m_dbz = 0;
    logic [7:0] m_q = 0, p_q = 0;
    logic [3:0] m_r = 0, p_r = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 0; m_busy <= 0; m_done <= 0; m_q <= 0; m_r <= 0; m_dbz <= 0;
        end else begin
            cyc    <= cyc + 1;
            m_done <= 1'b0;
            if (m_busy) begin
                if (cyc == m_due) begin
                    m_busy <= 0; m_done <= 1; m_q <= p_q; m_r <= p_r; m_dbz <= 0;
                end
            end else if (dif.start) begin
                if (dif.divisor == 0) begin
                    m_done <= 1; m_dbz <= 1; m_q <= 8'hFF; m_r <= dif.dividend[3:0];
                end else begin
                    m_busy <= 1;
                    m_due  <= cyc + 8;
                    p_q    <= 8'(dif.dividend / dif.divisor);
                    p_r    <= 4'(dif.dividend % dif.divisor);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc busy",   dif.busy,        m_busy);
            chk("cyc done",   dif.done,        m_done);
            chk("cyc quot",   dif.quotient,    m_q);
            chk("cyc rem",    dif.remainder,   m_r);
            chk("cyc dbz",    dif.div_by_zero, m_dbz);
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    // Called just after an edge; leaves caller 2 units after the accepting edge.
    task automatic launch(input int a, input int b);
        dif.start = 1'b1; dif.dividend = 8'(a); dif.divisor = 4'(b);
        step();
        dif.start = 1'b0;
    endtask

    task automatic wait_result(input string nm, input int q, input int r, input int dbz,
                               input int lat, input int n0);
        int n = n0;
        while (!dif.done && n < 20) begin
            step();
            n++;
        end
        chk({nm, " done"},    dif.done,        1);
        chk({nm, " latency"}, n,               lat);
        chk({nm, " quot"},    dif.quotient,    q);
        chk({nm, " rem"},     dif.remainder,   r);
        chk({nm, " dbz"},     dif.div_by_zero, dbz);
    endtask

    task automatic run(input string nm, input int a, input int b, input int q, input int r,
                       input int dbz, input int lat);
        step();
        launch(a, b);
        wait_result(nm, q, r, dbz, lat, 0);
    endtask

    initial begin
        dif.start = 0; dif.dividend = 0; dif.divisor = 0;
        repeat (3) step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("rst busy", dif.busy, 0);
        chk("rst done", dif.done, 0);
        chk("rst quot", dif.quotient, 0);
        chk("rst rem",  dif.remainder, 0);
        chk("rst dbz",  dif.div_by_zero, 0);

        run("200/7", 200, 7, 28, 4, 0, 8);
        run("255/1", 255, 1, 255, 0, 0, 8);
        repeat (3) step();
        chk("hold quot", dif.quotient, 255);
        chk("hold done", dif.done, 0);
        run("0/5",   0, 5, 0, 0, 0, 8);
        run("15/15", 15, 15, 1, 0, 0, 8);
        run("37/0",  37, 0, 255, 5, 1, 0);
        run("37/6",  37, 6, 6, 1, 0, 8);

        // Extra starts while busy must be dropped
        step();
        launch(100, 9);
        step(); step();
        dif.start = 1; dif.dividend = 5; dif.divisor = 1;
        step();
        dif.start = 0;
        step(); step();
        dif.start = 1; dif.dividend = 3; dif.divisor = 0;
        step();
        dif.start = 0;
        wait_result("100/9 ign", 11, 1, 0, 8, 6);

        // Back-to-back: new start in the DONE cycle
        run("b2b 200/7", 200, 7, 28, 4, 0, 8);
        launch(81, 4);
        chk("b2b old quot", dif.quotient, 28);
        wait_result("b2b 81/4", 20, 1, 0, 8, 0);

        // Reset during CALC
        step();
        launch(200, 7);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("abort busy", dif.busy, 0);
        chk("abort done", dif.done, 0);
        chk("abort quot", dif.quotient, 0);
        chk("abort rem",  dif.remainder, 0);
        repeat (2) step();
        rst_n = 1'b1;
        run("50/3", 50, 3, 16, 2, 0, 8);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) run("sweep", a, b, 255, a % 16, 1, 0);
                else        run("sweep", a, b, a / b, a % b, 0, 8);
            end
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential unsigned divider; the inverse companion to the team's 4x4 array multiplier.
- Takes an 8-bit dividend and a 4-bit divisor. Produces an 8-bit quotient and a 4-bit remainder by restoring division, one quotient bit per clock.
- Start/done handshake; sits beside the multiplier in the small-arithmetic datapath.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when not busy.
- dividend  in  DIVIDEND_W  unsigned dividend; captured on accepted start.
- divisor  in  DIVISOR_W  unsigned divisor; captured on accepted start.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse: result valid.
- quotient  out  DIVIDEND_W  result quotient; held until the next result.
- remainder  out  DIVISOR_W  result remainder; held until the next result.
- div_by_zero  out  1  flag for the current result; held with the result.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset: state=IDLE; busy, done, div_by_zero=0; quotient=0; remainder=0; internal registers cleared.
- States:
  - IDLE: waiting.
  - CALC: iterating.
  - DONE: one cycle, done=1.
- Accept:
  - start=1 at a rising edge while state is IDLE or DONE: capture the operands.
  - Clear the partial remainder (DIVISOR_W+1 bits).
  - Load the shift register with the dividend; set iteration count=0.
  - Go to CALC. busy=1 from the next cycle.
- start while in CALC is ignored; no queueing.
- Iteration (each CALC edge):
  - Form trial = {partial_rem[DIVISOR_W-1:0], shreg MSB}.
  - Compute diff = trial - {0,divisor} at DIVISOR_W+1 bits.
  - If there is no borrow, partial_rem=diff and the shifted-in quotient bit is 1.
  - Otherwise partial_rem=trial and the quotient bit is 0.
  - Shift the quotient bit into shreg LSB.
- Timing:
  - After DIVIDEND_W CALC edges: quotient=shreg, remainder=partial_rem[DIVISOR_W-1:0], state=DONE, busy=0, done=1.
  - Latency: done is high in the cycle exactly DIVIDEND_W edges after the accepting edge (8 with defaults).
- DONE lasts one cycle, then IDLE. done never stays high for two cycles unless a new divide-by-zero is accepted in DONE.
- Back-to-back: start in the DONE cycle is accepted; the next result follows 8 cycles later. quotient/remainder hold the old values until then.
- Divide by zero (divisor==0 at accept):
  - Skip CALC; state=DONE on the next edge with done=1, div_by_zero=1.
  - quotient=all ones; remainder=dividend[DIVISOR_W-1:0].
- div_by_zero is cleared on the next accepted start with a nonzero divisor, at the result edge.
- Invariants:
  - remainder < divisor always for a nonzero divisor.
  - quotient*divisor + remainder == dividend.
  - No overflow is possible.
- Reset mid-CALC: immediate abort, all outputs reset; the partial result is discarded.

Decomposition:
- Shared package: DIVIDEND_W and DIVISOR_W defaults; state enum {IDLE, CALC, DONE}; iteration counter width $clog2(DIVIDEND_W+1).
- One sub-module: div_trial_sub, a combinational DIVISOR_W+1-bit trial subtractor. Outputs diff and borrow. Kept separate so it can later be swapped for a carry-lookahead implementation.

Test Plan:
- Reset, then 200/7 with a one-cycle start → busy for 8 cycles; done pulse at edge 8; quotient=28, remainder=4, div_by_zero=0.
- 255/1, then 0/5, then 15/15 → (255,0), (0,0), (1,0); outputs hold between results.
- 37/0 → done one edge after start; div_by_zero=1, quotient=255, remainder=5. A following 37/6 gives (6,1) with div_by_zero=0.
- start pulsed at cycles 3 and 6 of a busy 100/9 → ignored; a single done with (11,1).
- start asserted in the DONE cycle of 200/7 with new operands 81/4 → second done exactly 8 edges later; result (20,1).
- rst_n low in CALC cycle 4 of 200/7 → immediate IDLE, all outputs 0. A new 50/3 after release gives (16,2).
- Random sweep over all 8x4 operand pairs → quotient and remainder match a reference model.
